// File: rtl/sopc_scope_nios2_dct_packer.sv
// -----------------------------------------------------------------------------
// sopc_scope_nios2_dct_packer
//
// Packs retired direct-conditional-branch outcomes into 2-bit codes
// ({1'b1, taken}). Up to 15 codes are accumulated in a 30-bit buffer, with the
// newest code in bits [1:0]. Completed frames are handed to the trace FIFO
// through a single-entry output slot with a valid/ready handshake.
//
// Ports:
//   clk          - single clock, rising edge
//   reset_n      - asynchronous active-low reset
//   trc_on       - trace enable; events are ignored while low
//   dct_valid    - one conditional branch retired this cycle
//   dct_taken    - branch outcome (1 = taken)
//   flush        - non-sequential event; closes the current frame
//   frame_ready  - consumer accepts frame_data this cycle
//   dct_buffer   - live accumulator (30 bits)
//   dct_count    - number of codes in the accumulator (0..15)
//   frame_valid  - a frame is held in the output slot
//   frame_data   - {count[3:0], buffer[29:0]} of the held frame
//   overflow     - sticky; set on the first dropped event
//   drop_count   - saturating count of dropped events
// -----------------------------------------------------------------------------
module sopc_scope_nios2_dct_packer #(
    parameter int DROP_W           = 8,
    parameter bit FLUSH_ON_TRC_OFF = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trc_on,
    input  logic              dct_valid,
    input  logic              dct_taken,
    input  logic              flush,
    input  logic              frame_ready,
    output logic [29:0]       dct_buffer,
    output logic [3:0]        dct_count,
    output logic              frame_valid,
    output logic [33:0]       frame_data,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t       r_slot;
    logic [29:0]       r_buf;
    logic [3:0]        r_cnt;
    logic [33:0]       r_frame;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              r_flush_pend;
    logic              r_trc_d;

    logic              w_full;
    logic              w_accept;
    logic              w_drop;
    logic [29:0]       w_n_buf;
    logic [3:0]        w_n_cnt;
    logic              w_trc_fall;
    logic              w_flush_close;
    logic              w_close;
    logic              w_slot_free;

    assign w_full      = (r_cnt == 4'd15);
    assign w_accept    = trc_on & dct_valid & ~w_full;
    assign w_drop      = trc_on & dct_valid & w_full;
    assign w_n_buf     = w_accept ? {r_buf[27:0], 1'b1, dct_taken} : r_buf;
    assign w_n_cnt     = w_accept ? (r_cnt + 4'd1) : r_cnt;
    assign w_trc_fall  = FLUSH_ON_TRC_OFF & r_trc_d & ~trc_on;
    // A flush-type close only matters when there is something to emit;
    // an empty accumulator neither emits a frame nor arms flush_pend.
    assign w_flush_close = (flush | r_flush_pend | w_trc_fall) & (w_n_cnt != 4'd0);
    assign w_close     = (w_n_cnt == 4'd15) | w_flush_close;
    assign w_slot_free = (r_slot == SLOT_EMPTY) | frame_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot       <= SLOT_EMPTY;
            r_buf        <= '0;
            r_cnt        <= '0;
            r_frame      <= '0;
            r_overflow   <= 1'b0;
            r_drop_cnt   <= '0;
            r_flush_pend <= 1'b0;
            r_trc_d      <= 1'b0;
        end else begin
            r_trc_d <= trc_on;

            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != {DROP_W{1'b1}}) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end

            if (w_close && w_slot_free) begin
                // Covers the back-to-back case: the old frame is consumed
                // this cycle and the new one takes its place.
                r_frame      <= {w_n_cnt, w_n_buf};
                r_slot       <= SLOT_FULL;
                r_buf        <= '0;
                r_cnt        <= '0;
                r_flush_pend <= 1'b0;
            end else begin
                // Slot busy (or no close): keep accumulating. A flush that
                // cannot be honoured yet is remembered so the frame closes
                // as soon as the slot frees, even if no new event arrives.
                r_buf <= w_n_buf;
                r_cnt <= w_n_cnt;
                if (w_close && w_flush_close) begin
                    r_flush_pend <= 1'b1;
                end
                if ((r_slot == SLOT_FULL) && frame_ready) begin
                    r_slot <= SLOT_EMPTY;
                end
            end
        end
    end

    assign dct_buffer  = r_buf;
    assign dct_count   = r_cnt;
    assign frame_valid = (r_slot == SLOT_FULL);
    assign frame_data  = r_frame;
    assign overflow    = r_overflow;
    assign drop_count  = r_drop_cnt;

endmodule

// File: tb/tb_sopc_scope_nios2_dct_packer.sv
// -----------------------------------------------------------------------------
// Testbench for sopc_scope_nios2_dct_packer.
// Stimulus pushes hand-computed frames into a queue; a monitor pops and
// compares on every frame handshake. Inline checks cover latency, hold,
// drop/overflow, trace-off and asynchronous reset behaviour.
// -----------------------------------------------------------------------------
module tb_sopc_scope_nios2_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        trc_on = 1'b1;
    logic        dct_valid = 1'b0;
    logic        dct_taken = 1'b0;
    logic        flush = 1'b0;
    logic        frame_ready = 1'b1;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frame_valid;
    logic [33:0] frame_data;
    logic        overflow;
    logic [7:0]  drop_count;

    int errors = 0;
    int checks = 0;
    logic [33:0] exp_q[$];

    sopc_scope_nios2_dct_packer #(
        .DROP_W(8),
        .FLUSH_ON_TRC_OFF(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .trc_on(trc_on),
        .dct_valid(dct_valid),
        .dct_taken(dct_taken),
        .flush(flush),
        .frame_ready(frame_ready),
        .dct_buffer(dct_buffer),
        .dct_count(dct_count),
        .frame_valid(frame_valid),
        .frame_data(frame_data),
        .overflow(overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; outputs are examined #1 after the edge.
    task automatic step(input logic v, input logic t, input logic f);
        dct_valid = v;
        dct_taken = t;
        flush     = f;
        @(posedge clk);
        #1;
        dct_valid = 1'b0;
        dct_taken = 1'b0;
        flush     = 1'b0;
    endtask

    // Monitor: one comparison per consumed frame.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && frame_valid && frame_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", {30'd0, frame_data}, 64'h0);
                end else begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    $display("frame out: data=%h expected=%h", frame_data, e);
                    chk("frame_data", {30'd0, frame_data}, {30'd0, e});
                end
            end
        end
    end

    initial begin
        // ---------------- reset state ----------------
        #2 reset_n = 1'b0;
        #10;
        chk("rst_buffer", {34'd0, dct_buffer}, 64'd0);
        chk("rst_count", {60'd0, dct_count}, 64'd0);
        chk("rst_valid", {63'd0, frame_valid}, 64'd0);
        chk("rst_data", {30'd0, frame_data}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        chk("rst_drops", {56'd0, drop_count}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(0, 0, 0);

        // ---------------- full frame, taken first ----------------
        step(1, 1, 0);
        chk("first_count", {60'd0, dct_count}, 64'd1);
        chk("first_buffer", {34'd0, dct_buffer}, 64'h3);
        for (int i = 1; i < 14; i++) step(1, (i % 2) == 0, 0);
        chk("count14", {60'd0, dct_count}, 64'd14);
        chk("count14_novalid", {63'd0, frame_valid}, 64'd0);
        exp_q.push_back({4'hF, 30'h3BBBBBBB});
        step(1, 1, 0);
        chk("full_valid", {63'd0, frame_valid}, 64'd1);
        chk("full_data", {30'd0, frame_data}, {30'd0, 4'hF, 30'h3BBBBBBB});
        chk("full_count0", {60'd0, dct_count}, 64'd0);
        step(0, 0, 0);
        chk("full_drained", {63'd0, frame_valid}, 64'd0);

        // ---------------- full frame, not-taken first ----------------
        exp_q.push_back({4'hF, 30'h2EEEEEEE});
        for (int i = 0; i < 15; i++) step(1, (i % 2) == 1, 0);
        chk("full2_valid", {63'd0, frame_valid}, 64'd1);
        step(0, 0, 0);

        // ---------------- partial flush ----------------
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        chk("part_count", {60'd0, dct_count}, 64'd3);
        chk("part_buffer", {34'd0, dct_buffer}, 64'h3F);
        exp_q.push_back({4'd3, 30'h0000003F});
        step(0, 0, 1);
        chk("part_valid", {63'd0, frame_valid}, 64'd1);
        chk("part_clear_cnt", {60'd0, dct_count}, 64'd0);
        chk("part_clear_buf", {34'd0, dct_buffer}, 64'd0);
        step(0, 0, 0);

        // ---------------- event and flush together ----------------
        step(1, 1, 0);
        step(1, 1, 0);
        exp_q.push_back({4'd3, 30'h0000003E});
        step(1, 0, 1);
        chk("same_data", {30'd0, frame_data}, {30'd0, 4'd3, 30'h0000003E});
        chk("same_count0", {60'd0, dct_count}, 64'd0);
        step(0, 0, 0);

        // flush with empty accumulator emits nothing
        step(0, 0, 1);
        chk("empty_flush", {63'd0, frame_valid}, 64'd0);
        step(0, 0, 0);
        chk("empty_flush_pend", {63'd0, frame_valid}, 64'd0);

        // ---------------- backpressure and drop ----------------
        frame_ready = 1'b0;
        exp_q.push_back({4'hF, 30'h3FFFFFFF});
        for (int i = 0; i < 15; i++) step(1, 1, 0);
        exp_q.push_back({4'hF, 30'h2AAAAAAA});
        for (int i = 0; i < 15; i++) step(1, 0, 0);
        chk("bp_hold", {30'd0, frame_data}, {30'd0, 4'hF, 30'h3FFFFFFF});
        chk("bp_blocked", {60'd0, dct_count}, 64'd15);
        for (int i = 0; i < 4; i++) step(1, 1, 0);
        chk("bp_drops", {56'd0, drop_count}, 64'd4);
        chk("bp_overflow", {63'd0, overflow}, 64'd1);
        chk("bp_buffer", {34'd0, dct_buffer}, 64'h2AAAAAAA);
        frame_ready = 1'b1;
        step(0, 0, 0);
        chk("bp_f2_valid", {63'd0, frame_valid}, 64'd1);
        chk("bp_f2_data", {30'd0, frame_data}, {30'd0, 4'hF, 30'h2AAAAAAA});
        chk("bp_f2_cnt", {60'd0, dct_count}, 64'd0);
        step(1, 1, 0);
        chk("bp_accepting", {60'd0, dct_count}, 64'd1);
        exp_q.push_back({4'd1, 30'h00000003});
        step(0, 0, 1);
        step(0, 0, 0);

        // ---------------- trace-off close ----------------
        for (int i = 0; i < 5; i++) step(1, (i % 2) == 0, 0);
        chk("toff_count", {60'd0, dct_count}, 64'd5);
        exp_q.push_back({4'd5, 30'h000003BB});
        trc_on = 1'b0;
        step(0, 0, 0);
        chk("toff_valid", {63'd0, frame_valid}, 64'd1);
        chk("toff_data", {30'd0, frame_data}, {30'd0, 4'd5, 30'h000003BB});
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        chk("toff_ignored", {60'd0, dct_count}, 64'd0);
        chk("toff_buf", {34'd0, dct_buffer}, 64'd0);
        chk("toff_nodrop", {56'd0, drop_count}, 64'd4);
        chk("toff_drained", {63'd0, frame_valid}, 64'd0);
        trc_on = 1'b1;
        step(0, 0, 0);

        // ---------------- reset mid-operation ----------------
        frame_ready = 1'b0;
        for (int i = 0; i < 15; i++) step(1, 1, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0);
        chk("mid_pre_valid", {63'd0, frame_valid}, 64'd1);
        chk("mid_pre_count", {60'd0, dct_count}, 64'd7);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_buffer", {34'd0, dct_buffer}, 64'd0);
        chk("mid_count", {60'd0, dct_count}, 64'd0);
        chk("mid_valid", {63'd0, frame_valid}, 64'd0);
        chk("mid_data", {30'd0, frame_data}, 64'd0);
        chk("mid_overflow", {63'd0, overflow}, 64'd0);
        chk("mid_drops", {56'd0, drop_count}, 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        frame_ready = 1'b1;
        step(0, 0, 0);
        exp_q.push_back({4'hF, 30'h2EEEEEEE});
        for (int i = 0; i < 15; i++) step(1, (i % 2) == 1, 0);
        chk("post_rst_data", {30'd0, frame_data}, {30'd0, 4'hF, 30'h2EEEEEEE});

        for (int i = 0; i < 3; i++) step(0, 0, 0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
